// File: rtl/spi_globals_pkg.sv
// spi_globals_pkg: shared constants, capture entry layout and FSM states for the SPI bus capture stage.
package spi_globals_pkg;
  localparam int SPI_CHAR_LENGTH = 8;
  localparam int SPI_MAX_CHAR = 32;
  localparam int SPI_CNT_W = 6;
  // Entries are sized for the widest legal character; the top slices them down.
  typedef struct packed {
    logic [SPI_MAX_CHAR-1:0] mosi_data;
    logic [SPI_MAX_CHAR-1:0] miso_data;
    logic [SPI_CNT_W-1:0]    bit_count;
    logic                    frame_end;
  } spi_capture_entry_s;
  typedef enum logic [1:0] {IDLE, ACTIVE, CLOSE} spi_state_e;
endpackage

// File: rtl/spi_capture_fifo.sv
// spi_capture_fifo: synchronous entry FIFO that drops pushes when full and flags a sticky overflow.
module spi_capture_fifo
  import spi_globals_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  spi_capture_entry_s push_data,
  input  logic               pop,
  output spi_capture_entry_s head,
  output logic               empty,
  output logic               overflow
);
  spi_capture_entry_s mem_q [DEPTH];
  spi_capture_entry_s mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, rd, wr;
  always_comb begin
    empty = cnt_q == '0;
    rd = pop & ~empty;
    wr = push & ((cnt_q != (AW+1)'(DEPTH)) | rd);
    mem_d = mem_q;
    if (wr) mem_d[wp_q] = push_data;
    wp_d = wp_q + AW'(wr);
    rp_d = rp_q + AW'(rd);
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    ovf_d = ovf_q | (push & ~wr);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign head = mem_q[rp_q];
  assign overflow = ovf_q;
endmodule

// File: rtl/spi_slave_bus_capture.sv
// spi_slave_bus_capture: oversamples raw SPI pins and queues whole MOSI/MISO characters per CS frame.
module spi_slave_bus_capture
  import spi_globals_pkg::*;
#(
  parameter int CHAR_LENGTH = SPI_CHAR_LENGTH,
  parameter int FIFO_DEPTH = 4,
  localparam int BCW = $clog2(CHAR_LENGTH + 1)
) (
  input  logic                   pclk,
  input  logic                   areset,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic                   msb_first,
  input  logic                   cs_n,
  input  logic                   sclk,
  input  logic                   mosi,
  input  logic                   miso,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CHAR_LENGTH-1:0] out_mosi_data,
  output logic [CHAR_LENGTH-1:0] out_miso_data,
  output logic [BCW-1:0]         out_bit_count,
  output logic                   out_frame_end,
  output logic                   frame_active,
  output logic                   overflow
);
  logic [3:0] s1_q, s1_d, s2_q, s2_d;
  logic [1:0] dly_q, dly_d;
  logic primed_q, primed_d, armed_q, armed_d;
  spi_state_e state_q, state_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, msb_q, msb_d;
  logic [BCW-1:0] cnt_q, cnt_d;
  logic [CHAR_LENGTH-1:0] mosi_q, mosi_d, miso_q, miso_d;
  logic rise, fall, samp, cs_rise, push, empty, unused_hi;
  spi_capture_entry_s entry, head;
  // Synced pins are {cs_n, sclk, mosi, miso}; armed needs cs_n seen high after reset so a frame
  // already in progress at reset release is never picked up mid-character.
  always_comb begin
    s1_d = {cs_n, sclk, mosi, miso};
    s2_d = s1_q;
    dly_d = s2_q[3:2];
    rise = s2_q[2] & ~dly_q[0];
    fall = ~s2_q[2] & dly_q[0];
    cs_rise = s2_q[3] & ~dly_q[1];
    samp = (cpol_q ^ cpha_q) ? fall : rise;
    primed_d = 1'b1;
    armed_d = armed_q | (primed_q & s1_q[3]);
    state_d = state_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    msb_d = msb_q;
    cnt_d = cnt_q;
    mosi_d = mosi_q;
    miso_d = miso_q;
    push = 1'b0;
    entry = '0;
    case (state_q)
      IDLE: if (armed_q && !s2_q[3]) begin
        state_d = ACTIVE;
        armed_d = 1'b0;
        cpol_d = cpol;
        cpha_d = cpha;
        msb_d = msb_first;
        cnt_d = '0;
        mosi_d = '0;
        miso_d = '0;
      end
      ACTIVE: begin
        if (samp) begin
          mosi_d = msb_q ? {mosi_q[CHAR_LENGTH-2:0], s2_q[1]} : mosi_q | (CHAR_LENGTH'(s2_q[1]) << cnt_q);
          miso_d = msb_q ? {miso_q[CHAR_LENGTH-2:0], s2_q[0]} : miso_q | (CHAR_LENGTH'(s2_q[0]) << cnt_q);
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == BCW'(CHAR_LENGTH)) begin
            push = 1'b1;
            entry = '{SPI_MAX_CHAR'(mosi_d), SPI_MAX_CHAR'(miso_d), SPI_CNT_W'(cnt_d), 1'b0};
            cnt_d = '0;
            mosi_d = '0;
            miso_d = '0;
          end
        end
        if (cs_rise) state_d = CLOSE;
      end
      CLOSE: begin
        push = 1'b1;
        entry = '{SPI_MAX_CHAR'(mosi_q), SPI_MAX_CHAR'(miso_q), SPI_CNT_W'(cnt_q), 1'b1};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      s1_q <= 4'b1000;
      s2_q <= 4'b1000;
      dly_q <= 2'b10;
      primed_q <= 1'b0;
      armed_q <= 1'b0;
      state_q <= IDLE;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      msb_q <= 1'b0;
      cnt_q <= '0;
      mosi_q <= '0;
      miso_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      dly_q <= dly_d;
      primed_q <= primed_d;
      armed_q <= armed_d;
      state_q <= state_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      msb_q <= msb_d;
      cnt_q <= cnt_d;
      mosi_q <= mosi_d;
      miso_q <= miso_d;
    end
  end
  spi_capture_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(pclk),
    .rst(areset),
    .push(push),
    .push_data(entry),
    .pop(out_valid & out_ready),
    .head(head),
    .empty(empty),
    .overflow(overflow)
  );
  assign out_valid = ~empty;
  assign out_mosi_data = head.mosi_data[CHAR_LENGTH-1:0];
  assign out_miso_data = head.miso_data[CHAR_LENGTH-1:0];
  assign out_bit_count = head.bit_count[BCW-1:0];
  assign out_frame_end = head.frame_end;
  assign frame_active = state_q == ACTIVE;
  assign unused_hi = ^{head.mosi_data >> CHAR_LENGTH, head.miso_data >> CHAR_LENGTH, head.bit_count >> BCW};
endmodule

// File: tb/tb_spi_slave_bus_capture.sv
// tb_spi_slave_bus_capture: directed SPI frames against hand-computed capture entries.
module tb_spi_slave_bus_capture;
  localparam int H = 50;
  logic pclk = 1'b0;
  logic areset, cpol, cpha, msb_first, cs_n, sclk, mosi, miso, out_ready;
  logic out_valid, out_frame_end, frame_active, overflow;
  logic [7:0] out_mosi_data, out_miso_data;
  logic [3:0] out_bit_count;
  logic [20:0] head_vec, prev_head;
  logic prev_stall;
  logic [20:0] got_q[$];
  logic [20:0] bp_exp [4];
  int tests = 0;
  int fails = 0;

  spi_slave_bus_capture #(.CHAR_LENGTH(8), .FIFO_DEPTH(4)) dut (
    .pclk(pclk),
    .areset(areset),
    .cpol(cpol),
    .cpha(cpha),
    .msb_first(msb_first),
    .cs_n(cs_n),
    .sclk(sclk),
    .mosi(mosi),
    .miso(miso),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mosi_data(out_mosi_data),
    .out_miso_data(out_miso_data),
    .out_bit_count(out_bit_count),
    .out_frame_end(out_frame_end),
    .frame_active(frame_active),
    .overflow(overflow)
  );

  assign head_vec = {out_mosi_data, out_miso_data, out_bit_count, out_frame_end};
  always #5 pclk = ~pclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_mode(input logic cp, input logic ch, input logic mf);
    cpol = cp;
    cpha = ch;
    msb_first = mf;
    sclk = cp;
    repeat (5) @(negedge pclk);
  endtask

  task automatic send_char(input logic [31:0] mo, input logic [31:0] mi, input int n, input bit msbf);
    for (int i = 0; i < n; i++) begin
      int b;
      b = msbf ? n - 1 - i : i;
      if (!cpha) begin
        mosi = mo[b];
        miso = mi[b];
        #H sclk = ~sclk;
        #H sclk = ~sclk;
      end else begin
        sclk = ~sclk;
        mosi = mo[b];
        miso = mi[b];
        #H sclk = ~sclk;
        #H;
      end
    end
  endtask

  task automatic begin_frame();
    cs_n = 1'b0;
    repeat (6) @(negedge pclk);
  endtask

  task automatic end_frame();
    #H cs_n = 1'b1;
    repeat (10) @(negedge pclk);
  endtask

  task automatic expect_entry(input string tag, input logic [7:0] m, input logic [7:0] s,
                              input logic [3:0] n, input logic fe);
    int k;
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge pclk);
      k++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_mosi"}, out_mosi_data, m);
    chk({tag, "_miso"}, out_miso_data, s);
    chk({tag, "_cnt"}, out_bit_count, n);
    chk({tag, "_fe"}, out_frame_end, fe);
    out_ready = 1'b1;
    @(negedge pclk);
    out_ready = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    miso = 1'b0;
    cpol = 1'b0;
    cpha = 1'b0;
    msb_first = 1'b1;
    out_ready = 1'b0;
    bp_exp[0] = {8'hC1, 8'h1C, 4'd8, 1'b0};
    bp_exp[1] = {8'hD2, 8'h2D, 4'd8, 1'b0};
    bp_exp[2] = {8'hE3, 8'h3E, 4'd8, 1'b0};
    bp_exp[3] = {8'h00, 8'h00, 4'd0, 1'b1};
    #23;
    chk("rst_valid", out_valid, 0);
    chk("rst_active", frame_active, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_mosi", out_mosi_data, 0);
    @(negedge pclk);
    areset = 1'b0;
    repeat (5) @(negedge pclk);

    // mode 0, MSB first, one character
    set_mode(1'b0, 1'b0, 1'b1);
    chk("m0_idle_active", frame_active, 0);
    begin_frame();
    chk("m0_active", frame_active, 1);
    send_char(32'hA5, 32'h3C, 8, 1'b1);
    end_frame();
    chk("m0_inactive", frame_active, 0);
    expect_entry("m0_char", 8'hA5, 8'h3C, 4'd8, 1'b0);
    expect_entry("m0_mark", 8'h00, 8'h00, 4'd0, 1'b1);
    chk("m0_empty", out_valid, 0);

    // mode 3, LSB first, two characters
    set_mode(1'b1, 1'b1, 1'b0);
    begin_frame();
    send_char(32'h01, 32'hC3, 8, 1'b0);
    send_char(32'h80, 32'h0F, 8, 1'b0);
    end_frame();
    expect_entry("m3_c0", 8'h01, 8'hC3, 4'd8, 1'b0);
    expect_entry("m3_c1", 8'h80, 8'h0F, 4'd8, 1'b0);
    expect_entry("m3_mark", 8'h00, 8'h00, 4'd0, 1'b1);

    // mode 1, partial character of 5 bits closes the frame
    set_mode(1'b0, 1'b1, 1'b1);
    begin_frame();
    send_char(32'h16, 32'h0D, 5, 1'b1);
    end_frame();
    expect_entry("m1_part", 8'h16, 8'h0D, 4'd5, 1'b1);
    chk("m1_empty", out_valid, 0);

    // overflow with consumer stalled
    set_mode(1'b0, 1'b0, 1'b1);
    begin_frame();
    send_char(32'h11, 32'hEE, 8, 1'b1);
    send_char(32'h22, 32'hDD, 8, 1'b1);
    send_char(32'h33, 32'hCC, 8, 1'b1);
    send_char(32'h44, 32'hBB, 8, 1'b1);
    repeat (5) @(negedge pclk);
    chk("ov_before", overflow, 0);
    send_char(32'h55, 32'hAA, 8, 1'b1);
    repeat (5) @(negedge pclk);
    chk("ov_after5", overflow, 1);
    send_char(32'h66, 32'h99, 8, 1'b1);
    end_frame();
    expect_entry("ov_e0", 8'h11, 8'hEE, 4'd8, 1'b0);
    expect_entry("ov_e1", 8'h22, 8'hDD, 4'd8, 1'b0);
    expect_entry("ov_e2", 8'h33, 8'hCC, 4'd8, 1'b0);
    expect_entry("ov_e3", 8'h44, 8'hBB, 4'd8, 1'b0);
    chk("ov_drained", out_valid, 0);
    chk("ov_sticky", overflow, 1);

    // asynchronous reset mid-character
    begin_frame();
    send_char(32'h5, 32'h2, 3, 1'b1);
    chk("ar_active_before", frame_active, 1);
    #3 areset = 1'b1;
    #1;
    chk("ar_active", frame_active, 0);
    chk("ar_ovf", overflow, 0);
    chk("ar_valid", out_valid, 0);
    chk("ar_mosi", out_mosi_data, 0);
    repeat (3) @(negedge pclk);
    areset = 1'b0;
    repeat (5) @(negedge pclk);
    chk("ar_no_resume", frame_active, 0);
    send_char(32'h1F, 32'h00, 5, 1'b1);
    end_frame();
    chk("ar_no_entry", out_valid, 0);
    begin_frame();
    send_char(32'h5A, 32'h96, 8, 1'b1);
    end_frame();
    expect_entry("ar_c0", 8'h5A, 8'h96, 4'd8, 1'b0);
    expect_entry("ar_mark", 8'h00, 8'h00, 4'd0, 1'b1);

    // backpressure: out_ready toggles every cycle during three characters
    prev_stall = 1'b0;
    prev_head = '0;
    fork
      begin
        begin_frame();
        send_char(32'hC1, 32'h1C, 8, 1'b1);
        send_char(32'hD2, 32'h2D, 8, 1'b1);
        send_char(32'hE3, 32'h3E, 8, 1'b1);
        end_frame();
      end
      begin
        repeat (400) begin
          @(negedge pclk);
          if (prev_stall) begin
            chk("bp_stall_valid", out_valid, 1);
            chk("bp_stall_hold", head_vec, prev_head);
          end
          out_ready = ~out_ready;
          if (out_valid && out_ready) got_q.push_back(head_vec);
          prev_stall = out_valid && !out_ready;
          prev_head = head_vec;
        end
      end
    join
    out_ready = 1'b0;
    chk("bp_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("bp_entry", (got_q.size() > i) ? got_q[i] : 21'h1FFFFF, bp_exp[i]);
    chk("bp_ovf", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_slave_bus_capture.md
Name: spi_slave_bus_capture

Overview:
Synthesizable capture stage that sits directly upstream of the slave monitor BFM. It oversamples the raw SPI pins (cs_n, sclk, mosi, miso) on the system clock and deserializes MOSI and MISO characters per chip-select frame according to CPOL/CPHA. Completed characters and frame-end markers go into a small FIFO, which the slave monitor BFM drains with a valid/ready handshake. The monitor proxy therefore receives whole characters instead of pin wiggles.

Parameters:
CHAR_LENGTH, 8, bits per character; legal range 2..32.
FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and at least 2.

Ports:
pclk  input  1  system clock; must be at least 4x the sclk frequency.
areset  input  1  asynchronous reset, active-high.
cpol  input  1  clock polarity; latched at frame start.
cpha  input  1  clock phase; latched at frame start.
msb_first  input  1  1 = first bit received lands in the MSB; latched at frame start.
cs_n  input  1  raw chip select, active-low, asynchronous to pclk.
sclk  input  1  raw SPI clock.
mosi  input  1  raw master-out line.
miso  input  1  raw slave-out line.
out_valid  output  1  FIFO head entry is valid.
out_ready  input  1  consumer accepts the head entry.
out_mosi_data  output  CHAR_LENGTH  captured MOSI character; unused bits are 0.
out_miso_data  output  CHAR_LENGTH  captured MISO character; unused bits are 0.
out_bit_count  output  $clog2(CHAR_LENGTH+1)  number of valid bits in the entry.
out_frame_end  output  1  entry closes the current CS frame.
frame_active  output  1  a CS frame is in progress.
overflow  output  1  sticky: at least one entry was dropped because the FIFO was full.

Behaviour:
- Reset: areset is asynchronous and active-high. It clears all of the following to 0 on assertion, regardless of pclk:
  - outputs, FIFO pointers and the state machine (goes to IDLE);
  - synchronizer flops, except the cs_n synchronizer, which resets to 1 and is treated as deasserted.
  - A frame in progress when areset asserts is discarded. After release, capture resumes only at the next cs_n falling edge.
- Input synchronization:
  - cs_n, sclk, mosi and miso each pass through a 2-flop synchronizer.
  - An edge detector compares each synced value with a registered copy (1 further cycle).
  - Total latency from pin to detected edge: 3 pclk cycles. mosi and miso travel the same pipeline, so data stays aligned with its sclk edge.
- Sample edge selection: leading edge = rising when cpol=0, falling when cpol=1. cpha=0 samples on the leading edge; cpha=1 samples on the trailing edge.
- State machine:
  - IDLE: waits for a synced cs_n falling edge. It then latches cpol, cpha and msb_first, clears the shifters and bit counter, sets frame_active=1, and moves to ACTIVE.
  - ACTIVE, on each sample edge:
    - shift mosi and miso into their shifters;
    - if msb_first=1, shift toward the MSB; if msb_first=0, place the bit at index bit_cnt;
    - increment bit_cnt.
  - ACTIVE, when bit_cnt reaches CHAR_LENGTH: push {mosi, miso, CHAR_LENGTH, frame_end=0} in the same cycle and reset bit_cnt to 0.
  - ACTIVE, on a synced cs_n rising edge: go to CLOSE. A sample edge detected in the same cycle is applied first.
  - CLOSE (1 cycle):
    - if bit_cnt > 0, push the partial entry {data, bit_cnt, frame_end=1};
    - if bit_cnt = 0, push a marker {0, 0, 0, frame_end=1};
    - clear frame_active and return to IDLE.
- Partial-character packing: msb_first=1 partial data is right-justified; received bits occupy [bit_cnt-1:0].
- Ignored events: sclk edges while in IDLE or CLOSE. A cs_n falling edge while in CLOSE is honored in the following IDLE cycle, because the edge detector holds it as a level check (synced cs_n=0 in IDLE starts a frame).
- FIFO:
  - Registered output; a push becomes visible on out_valid the cycle after the push.
  - Pop occurs when out_valid && out_ready. Simultaneous push and pop at full is allowed: the push succeeds.
  - A push when full without a simultaneous pop is dropped and sets overflow=1, sticky until areset.
  - While out_valid=1 and out_ready=0, all out_* data fields hold stable.
- Parameter and mode rules:
  - cpol, cpha and msb_first changing mid-frame have no effect until the next frame.
  - bit_cnt width is $clog2(CHAR_LENGTH+1); its wrap is controlled by the explicit reset at CHAR_LENGTH.

Decomposition:
- spi_globals_pkg (shared): CHAR_LENGTH default constant, entry struct spi_capture_entry_s {mosi_data, miso_data, bit_count, frame_end}, state enum {IDLE, ACTIVE, CLOSE}.
- Sub-module spi_capture_fifo: a synchronous FIFO of spi_capture_entry_s with push/pop, full/empty and the drop-on-full rule.
- The synchronizer, edge detection and state machine stay in the top module.

Test Plan:
- Directed scenarios, one per line (stimulus -> required response):
- Mode 0 (cpol=0, cpha=0, msb_first=1), one frame, MOSI 8'hA5, MISO 8'h3C -> entry {A5, 3C, 8, 0}, then marker {0, 0, 0, 1}; frame_active high only between cs_n edges (plus sync latency).
- Mode 3, msb_first=0, 2-char frame MOSI 8'h01, 8'h80 -> entries 8'h01, 8'h80, then marker; bit order verified by the LSB-first placement.
- Mode 1, cs_n deasserted after 5 bits MOSI 1,0,1,1,0 (msb_first=1) -> single entry {5'b10110 right-justified = 8'h16, bit_count=5, frame_end=1}.
- out_ready held 0, 6 chars sent with FIFO_DEPTH=4 -> first 4 entries retained in order, overflow=1 after the 5th push and still 1 after the drain; the 5th and 6th characters and the marker are lost.
- areset asserted mid-character (after 3 bits) -> all outputs 0 immediately and no partial entry; the next frame 8'h5A is captured cleanly.
- Backpressure: out_ready toggled every other cycle during 3 back-to-back chars -> no loss, data stable while stalled, order preserved.
